// File: rtl/frame_window_feeder.sv
// rtl/frame_window_feeder.sv - overlapping frame buffer and coefficient feeder for the windowing multiplier
// Optional build macro: HALF_COEF_EN (ROM holds only the symmetric half of the window).
module frame_window_feeder #(
   parameter int FRAME_LEN = 256,
   parameter int SHIFT     = 128,
   parameter int AW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [16:0]   sample_in,
   input  logic          sample_valid,
`ifdef HALF_COEF_EN
   output logic [AW-2:0] coef_addr,
`else
   output logic [AW-1:0] coef_addr,
`endif
   input  logic [4:0]    coef_data,
   output logic [16:0]   win_sample,
   output logic [4:0]    win_coef,
   output logic          win_en,
   output logic          win_first,
   output logic          win_last,
   output logic          wout_valid,
   output logic          frame_busy,
   output logic [15:0]   frame_cnt,
   output logic          overrun
);

   localparam int DEPTH = 2 * FRAME_LEN;
   localparam logic [AW+1:0] OCC_FULL  = (AW+2)'(DEPTH);
   localparam logic [AW+1:0] OCC_FRAME = (AW+2)'(FRAME_LEN);
   localparam logic [AW+1:0] OCC_SHIFT = (AW+2)'(SHIFT);
   localparam logic [AW:0]   PTR_SHIFT = (AW+1)'(SHIFT);
   localparam logic [AW-1:0] N_LAST    = AW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, READ, ISSUE, DONE} state_t;

   state_t        state, state_nxt;
   logic [16:0]   mem [DEPTH];
   logic [16:0]   rd_data;
   logic [AW:0]   wr_ptr, base_ptr, rd_addr;
   logic [AW+1:0] occ;
   logic [AW-1:0] n;
   logic [1:0]    en_pipe;
   logic          accept, last_n, start, issue, done;

   assign accept     = sample_valid && (occ < OCC_FULL);
   assign last_n     = (n == N_LAST);
   assign rd_addr    = base_ptr + {1'b0, n};
   assign wout_valid = en_pipe[1];

`ifdef HALF_COEF_EN
   // Upper half of the window mirrors the lower half: FRAME_LEN-1-n is ~n.
   assign coef_addr = n[AW-1] ? ~n[AW-2:0] : n[AW-2:0];
`else
   assign coef_addr = n;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (occ >= OCC_FRAME) state_nxt = READ;
         READ:    state_nxt = ISSUE;
         ISSUE:   state_nxt = last_n ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start = 1'b0;
      issue = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE:    start = (occ >= OCC_FRAME);
         ISSUE:   issue = 1'b1;
         DONE:    done  = 1'b1;
         default: ;
      endcase
   end

   // Buffer storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= sample_in;
      if (state == READ) rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         base_ptr   <= '0;
         occ        <= '0;
         n          <= '0;
         win_sample <= '0;
         win_coef   <= '0;
         win_en     <= 1'b0;
         win_first  <= 1'b0;
         win_last   <= 1'b0;
         en_pipe    <= '0;
         frame_busy <= 1'b0;
         frame_cnt  <= '0;
         overrun    <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (sample_valid && !accept) overrun <= 1'b1;
         occ <= occ + (AW+2)'(accept) - (done ? OCC_SHIFT : '0);

         if (start) begin
            n          <= '0;
            frame_busy <= 1'b1;
         end else if (issue && !last_n) begin
            n <= n + 1'b1;
         end

         win_en    <= issue;
         win_first <= issue && (n == '0);
         win_last  <= issue && last_n;
         if (issue) begin
            win_sample <= rd_data;
            win_coef   <= coef_data;
         end
         en_pipe <= {en_pipe[0], win_en};

         if (done) begin
            base_ptr   <= base_ptr + PTR_SHIFT;
            frame_cnt  <= frame_cnt + 16'd1;
            frame_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_window_feeder.sv
// tb/tb_frame_window_feeder.sv - self-checking bench for frame_window_feeder (FRAME_LEN=8, SHIFT=4)
// Optional build macro: HALF_COEF_EN (expected coefficients follow the mirrored ROM).
module tb_frame_window_feeder;

   localparam int FL = 8;
   localparam int SH = 4;
   localparam int AW = 3;
   localparam int DEP = 2 * FL;

   logic        clk = 1'b0;
   logic        reset;
   logic [16:0] sample_in;
   logic        sample_valid;
`ifdef HALF_COEF_EN
   logic [AW-2:0] coef_addr;
`else
   logic [AW-1:0] coef_addr;
`endif
   logic [4:0]  coef_data;
   logic [16:0] win_sample;
   logic [4:0]  win_coef;
   logic        win_en, win_first, win_last, wout_valid, frame_busy, overrun;
   logic [15:0] frame_cnt;

   frame_window_feeder #(.FRAME_LEN(FL), .SHIFT(SH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .coef_addr(coef_addr), .coef_data(coef_data), .win_sample(win_sample),
      .win_coef(win_coef), .win_en(win_en), .win_first(win_first), .win_last(win_last),
      .wout_valid(wout_valid), .frame_busy(frame_busy), .frame_cnt(frame_cnt),
      .overrun(overrun)
   );

   always #5 clk = ~clk;
   assign coef_data = 5'(coef_addr) + 5'd1;

   int checks = 0;
   int errors = 0;

   // Model state: every accepted sample since reset, frames seen, pulse position.
   logic [16:0] hist [$];
   logic [16:0] cap_s [$];
   logic [4:0]  cap_c [$];
   logic        m_ovr;
   int          seen, pos, cyc, last_cyc;
   logic        en_d1, en_d2;
   logic [16:0] hold_s;
   logic [4:0]  hold_c;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_coef(input int p);
`ifdef HALF_COEF_EN
      return 5'((p < FL/2) ? p : FL-1-p) + 5'd1;
`else
      return 5'(p) + 5'd1;
`endif
   endfunction

   task automatic write(input logic [16:0] v, input int gap);
      int occ_m;
      occ_m = hist.size() - SH * seen;
      sample_in    = v;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      if (occ_m < DEP) hist.push_back(v);
      else             m_ovr = 1'b1;
      repeat (gap - 1) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      hist.delete();
      m_ovr = 1'b0;
      #1;
      chk("rst_win_en", win_en, 0);
      chk("rst_win_first", win_first, 0);
      chk("rst_win_last", win_last, 0);
      chk("rst_wout_valid", wout_valid, 0);
      chk("rst_frame_busy", frame_busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_win_sample", win_sample, 0);
      chk("rst_win_coef", win_coef, 0);
      chk("rst_coef_addr", coef_addr, 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_frames(input int nf, input int budget);
      int b;
      b = budget;
      while (seen < nf && b > 0) begin @(posedge clk); #1; b--; end
      chk("frame_wait", seen >= nf, 1);
   endtask

   initial begin
      reset = 1'b1;
      sample_in = '0;
      sample_valid = 1'b0;
      m_ovr = 1'b0;
      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               seen = 0; pos = 0; cyc = 0; last_cyc = 0;
               en_d1 = 1'b0; en_d2 = 1'b0; hold_s = '0; hold_c = '0;
               cap_s.delete(); cap_c.delete();
            end else begin
               int idx;
               cyc++;
               chk("frame_cnt", frame_cnt, seen);
               chk("overrun", overrun, m_ovr);
               chk("wout_valid", wout_valid, en_d2);
               if (win_en) begin
                  if (pos > 0) chk("pulse_spacing", cyc - last_cyc, 2);
                  else         chk("no_back_to_back", en_d1, 0);
                  if (pos == 0) chk("frame_ready", hist.size() >= seen*SH + FL, 1);
                  idx = seen * SH + pos;
                  chk("sample_avail", idx < hist.size(), 1);
                  if (idx < hist.size()) chk("win_sample", win_sample, hist[idx]);
                  chk("win_coef", win_coef, exp_coef(pos));
                  chk("win_first", win_first, pos == 0);
                  chk("win_last", win_last, pos == FL-1);
                  cap_s.push_back(win_sample);
                  cap_c.push_back(win_coef);
                  hold_s = win_sample;
                  hold_c = win_coef;
                  last_cyc = cyc;
                  pos++;
                  if (pos == FL) begin pos = 0; seen++; end
               end else begin
                  chk("first_idle", win_first, 0);
                  chk("last_idle", win_last, 0);
                  chk("sample_hold", win_sample, hold_s);
                  chk("coef_hold", win_coef, hold_c);
               end
               if (pos > 0) chk("frame_busy", frame_busy, 1);
               en_d2 = en_d1;
               en_d1 = win_en;
            end
         end
      join_none

      @(posedge clk); #1;
      do_reset();

      // First frame: samples 1..8, one every 4 cycles.
      for (int v = 1; v <= 8; v++) write(17'(v), 4);
      wait_frames(1, 100);
      chk("first_frame_cnt", frame_cnt, 1);
      chk("first_cap_size", cap_s.size(), 8);
      for (int i = 0; i < 8; i++) chk("first_frame_sample", cap_s[i], 17'(i + 1));
`ifdef HALF_COEF_EN
      chk("first_coef_last", cap_c[7], 1);
`else
      chk("first_coef_last", cap_c[7], 8);
`endif

      // Overlap: 9..12 completes the second frame 5..12.
      for (int v = 9; v <= 12; v++) write(17'(v), 4);
      wait_frames(2, 100);
      chk("overlap_frame_cnt", frame_cnt, 2);
      chk("overlap_overrun", overrun, 0);
      for (int i = 0; i < 8; i++) chk("overlap_sample", cap_s[8 + i], 17'(i + 5));

      // Most negative sample passes through untouched.
      write(17'h10000, 3);
      for (int v = 14; v <= 16; v++) write(17'(v), 3);
      wait_frames(3, 100);
      chk("sign_frame_cnt", frame_cnt, 3);
      chk("sign_sample", cap_s[20], 17'h10000);
`ifdef HALF_COEF_EN
      chk("sign_coef", cap_c[20], 4);
`else
      chk("sign_coef", cap_c[20], 5);
`endif

      // Overrun: 24 back-to-back writes, only the first 16 fit.
      do_reset();
      for (int v = 101; v <= 124; v++) write(17'(v), 1);
      wait_frames(3, 200);
      repeat (30) begin @(posedge clk); #1; end
      chk("ovr_flag", overrun, 1);
      chk("ovr_frame_cnt", frame_cnt, 3);
      chk("ovr_cap_size", cap_s.size(), 24);
      chk("ovr_last_sample", cap_s[23], 116);
      chk("ovr_frame2_first", cap_s[16], 109);

      // Reset mid-frame, then a fresh frame needs 8 new samples.
      do_reset();
      for (int v = 201; v <= 208; v++) write(17'(v), 1);
      begin
         int b;
         b = 60;
         while (pos < 3 && b > 0) begin @(posedge clk); #1; b--; end
         chk("midframe_reach", pos >= 3, 1);
         chk("midframe_busy", frame_busy, 1);
      end
      do_reset();
      repeat (10) begin @(posedge clk); #1; end
      chk("midframe_no_pulse", cap_s.size(), 0);
      for (int v = 301; v <= 308; v++) write(17'(v), 2);
      wait_frames(1, 100);
      chk("fresh_first_sample", cap_s[0], 301);
      chk("fresh_last_sample", cap_s[7], 308);
      chk("fresh_frame_cnt", frame_cnt, 1);

      repeat (5) begin @(posedge clk); #1; end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
